alu_issue_stage: RTL
====================

Name: alu_issue_stage

Overview:
Decode/issue stage of the 2-stage MIPS pipeline and the producer side of the ALU control interface. Accepts fetched instructions through a valid/ready handshake, decodes opcode/funct into the 3-bit ALU operation code, shift amount and operands, then registers them into the EX pipeline register that drives the ALU. Handles RAW hazards against the instruction in EX, EX stalls, and branch flush.

Parameters:
DATA_W, 32, datapath width.
RA_W, 5, register address width.
FUNCT_SGT, 6'h2B, R-type funct code mapped to the set-greater-than operation (op 7).

Ports:
clk  in  1  clock, rising edge.
reset  in  1  asynchronous, active-high reset.
instr_valid  in  1  fetch presents an instruction.
instr  in  32  instruction word.
instr_ready  out  1  instruction accepted this cycle (combinational).
rs_addr  out  RA_W  regfile read address A = instr[25:21] (combinational).
rt_addr  out  RA_W  regfile read address B = instr[20:16] (combinational).
rs_data  in  DATA_W  regfile read data A.
rt_data  in  DATA_W  regfile read data B.
ex_result  in  DATA_W  ALU result of the instruction currently in EX.
ex_stall  in  1  EX cannot advance; hold the pipeline register.
branch_taken  in  1  branch resolved taken in EX; squash decode.
alu_valid  out  1  EX register holds a live instruction.
alu_a  out  DATA_W  ALU operand a.
alu_b  out  DATA_W  ALU operand b.
alu_signal  out  3  ALU op: 0 add, 1 sub, 2 and, 3 or, 4 sll, 5 srl, 6 slt, 7 sgt.
alu_shiftamt  out  5  shift amount.
alu_dest  out  RA_W  writeback register.
alu_wen  out  1  writeback enable.
illegal_instr  out  1  one-cycle pulse: undecodable instruction accepted.

Behaviour:
- Reset (async): every registered output is 0, including alu_valid, alu_a, alu_b, alu_signal, alu_shiftamt, alu_dest, alu_wen and illegal_instr. Any in-flight instruction is discarded.
- Latency: an instruction accepted at edge N appears on the alu_* outputs after edge N.
- Handshake:
  - instr_ready = !ex_stall && !hazard_stall.
  - Accept = instr_valid && instr_ready.
  - Cycle with ready and no valid loads a bubble: alu_valid=0, alu_wen=0.
- Stall: ex_stall=1 holds all EX registers unchanged.
- Flush priority: branch_taken=1 forces alu_valid=0 and alu_wen=0 at the next edge, overriding ex_stall. instr_ready is reported 1 that cycle, so the presented instruction is consumed and discarded (no illegal pulse).
- R-type decode (op 0x00), with rd = dest:
  - funct 0x20 add → 0; 0x22 sub → 1; 0x24 and → 2; 0x25 or → 3; 0x2A slt → 6; FUNCT_SGT → 7. For these, a = rs, b = rt.
  - funct 0x00 sll → 4; 0x02 srl → 5. For shifts, a = rt, b = 0, shiftamt = instr[10:6].
- I-type decode, with rt = dest:
  - 0x08 addi → 0, b = sign-extended imm16.
  - 0x0A slti → 6, sign-extended imm16.
  - 0x0C andi → 2, zero-extended imm16.
  - 0x0D ori → 3, zero-extended imm16.
  - 0x04 beq → 1, b = rt, alu_wen = 0.
- shiftamt is 0 for all non-shift ops.
- alu_wen = 0 whenever dest == 0. Word 0x00000000 (sll $0) is a valid NOP.
- Any other opcode or funct: accepted, issued as a bubble (alu_valid=0), illegal_instr pulses for exactly one cycle.
- Hazard condition: alu_valid && alu_wen && !ex_stall && (rs or rt of the incoming instruction, where used) == alu_dest.

Optional Feature:
FORWARDING_EN
- Defined:
  - Hazard operands take ex_result instead of rs_data/rt_data.
  - hazard_stall is always 0, so back-to-back dependent instructions issue without a gap.
- Undefined:
  - hazard_stall = hazard condition. Drive instr_ready=0 and load a bubble.
  - Next cycle the regfile holds the written value and the instruction issues: 1-cycle penalty per RAW.

Decomposition:
- Shared package alu_pkg:
  - ALU op code constants (ALU_ADD … ALU_SGT).
  - Opcode and funct constants.
  - Field-slice widths.
- The ALU itself consumes the same op constants.
- One sub-module, alu_decode: purely combinational instr → {op, imm-select, sign-ext, dest, wen, uses_rs, uses_rt, illegal}.
- Sequencing, hazard logic and the EX register stay in alu_issue_stage.

Test Plan:
- Reset mid-issue with alu_valid=1 → all outputs 0 immediately; first instruction after release issues 1 cycle after accept.
- addi $3,$0,-5 (0x2003FFFB), rs_data=0 → alu_signal=0, alu_b=0xFFFFFFFB, alu_dest=3, alu_wen=1; then ori $4,$0,0x8000 → alu_b=0x00008000, alu_signal=3.
- sll $2,$5,7 with rt_data=0x1 → alu_a=0x1, alu_shiftamt=7, alu_signal=4; NOP 0x00000000 → alu_valid=1, alu_wen=0.
- add $1,$2,$3 then sub $4,$1,$1, ex_result=0x10:
  - FORWARDING_EN: sub issues next cycle with a=b=0x10.
  - Without it: instr_ready=0 for one cycle, bubble, then sub issues.
- ex_stall=1 for 3 cycles → outputs frozen, instr_ready=0; branch_taken during stall → alu_valid=0 next edge.
- Opcode 0x3F → illegal_instr high exactly one cycle, alu_valid=0.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared constants for the ALU control interface: ALU op codes, MIPS opcode/funct
// values, instruction field widths and the decoded operand-b source select.
package alu_pkg;

    localparam int OPCODE_W = 6;
    localparam int FUNCT_W  = 6;
    localparam int SHAMT_W  = 5;
    localparam int IMM_W    = 16;
    localparam int REG_W    = 5;

    typedef enum logic [2:0] {
        ALU_ADD = 3'd0,
        ALU_SUB = 3'd1,
        ALU_AND = 3'd2,
        ALU_OR  = 3'd3,
        ALU_SLL = 3'd4,
        ALU_SRL = 3'd5,
        ALU_SLT = 3'd6,
        ALU_SGT = 3'd7
    } alu_op_e;

    localparam logic [OPCODE_W-1:0] OP_RTYPE = 6'h00;
    localparam logic [OPCODE_W-1:0] OP_BEQ   = 6'h04;
    localparam logic [OPCODE_W-1:0] OP_ADDI  = 6'h08;
    localparam logic [OPCODE_W-1:0] OP_SLTI  = 6'h0A;
    localparam logic [OPCODE_W-1:0] OP_ANDI  = 6'h0C;
    localparam logic [OPCODE_W-1:0] OP_ORI   = 6'h0D;

    localparam logic [FUNCT_W-1:0] FN_SLL = 6'h00;
    localparam logic [FUNCT_W-1:0] FN_SRL = 6'h02;
    localparam logic [FUNCT_W-1:0] FN_ADD = 6'h20;
    localparam logic [FUNCT_W-1:0] FN_SUB = 6'h22;
    localparam logic [FUNCT_W-1:0] FN_AND = 6'h24;
    localparam logic [FUNCT_W-1:0] FN_OR  = 6'h25;
    localparam logic [FUNCT_W-1:0] FN_SLT = 6'h2A;

    typedef enum logic [1:0] {
        BSEL_RT   = 2'd0,
        BSEL_IMM  = 2'd1,
        BSEL_ZERO = 2'd2
    } bsel_e;

    // Shifts take their operand from rt and their amount from the shamt field.
    function automatic logic is_shift(input logic [2:0] op);
        return (op == ALU_SLL) || (op == ALU_SRL);
    endfunction

endpackage

// File: rtl/alu_decode.sv
// Combinational MIPS decoder: opcode/funct/rt/rd to ALU op, operand-b source,
// immediate extension, destination, writeback enable, operand usage and illegal flag.
module alu_decode
    import alu_pkg::*;
#(
    parameter int              RA_W      = 5,
    parameter logic [5:0]      FUNCT_SGT = 6'h2B
) (
    input  logic [5:0]      opcode,
    input  logic [5:0]      funct,
    input  logic [RA_W-1:0] rt,
    input  logic [RA_W-1:0] rd,
    output logic [2:0]      op,
    output logic [1:0]      bsel,
    output logic            sign_ext,
    output logic [RA_W-1:0] dest,
    output logic            wen,
    output logic            uses_rs,
    output logic            uses_rt,
    output logic            illegal
);

    logic writes_s;

    // Field decode; anything not matched stays illegal with no operand usage.
    always_comb begin
        op       = ALU_ADD;
        bsel     = BSEL_RT;
        sign_ext = 1'b0;
        dest     = {RA_W{1'b0}};
        uses_rs  = 1'b0;
        uses_rt  = 1'b0;
        illegal  = 1'b1;
        writes_s = 1'b0;
        case (opcode)
            OP_RTYPE: begin
                dest     = rd;
                uses_rs  = 1'b1;
                uses_rt  = 1'b1;
                illegal  = 1'b0;
                writes_s = 1'b1;
                case (funct)
                    FN_ADD:    op = ALU_ADD;
                    FN_SUB:    op = ALU_SUB;
                    FN_AND:    op = ALU_AND;
                    FN_OR:     op = ALU_OR;
                    FN_SLT:    op = ALU_SLT;
                    FUNCT_SGT: op = ALU_SGT;
                    FN_SLL: begin
                        op      = ALU_SLL;
                        bsel    = BSEL_ZERO;
                        uses_rs = 1'b0;
                    end
                    FN_SRL: begin
                        op      = ALU_SRL;
                        bsel    = BSEL_ZERO;
                        uses_rs = 1'b0;
                    end
                    default: begin
                        dest     = {RA_W{1'b0}};
                        uses_rs  = 1'b0;
                        uses_rt  = 1'b0;
                        illegal  = 1'b1;
                        writes_s = 1'b0;
                    end
                endcase
            end
            OP_ADDI, OP_SLTI, OP_ANDI, OP_ORI: begin
                dest     = rt;
                bsel     = BSEL_IMM;
                uses_rs  = 1'b1;
                illegal  = 1'b0;
                writes_s = 1'b1;
                sign_ext = (opcode == OP_ADDI) || (opcode == OP_SLTI);
                if (opcode == OP_ADDI) begin
                    op = ALU_ADD;
                end else if (opcode == OP_SLTI) begin
                    op = ALU_SLT;
                end else if (opcode == OP_ANDI) begin
                    op = ALU_AND;
                end else begin
                    op = ALU_OR;
                end
            end
            OP_BEQ: begin
                op      = ALU_SUB;
                dest    = rt;
                uses_rs = 1'b1;
                uses_rt = 1'b1;
                illegal = 1'b0;
            end
            default: begin
                illegal = 1'b1;
            end
        endcase
        wen = writes_s && (dest != {RA_W{1'b0}});
    end

endmodule

// File: rtl/alu_issue_stage.sv
// Decode/issue stage feeding the EX pipeline register of the ALU, with RAW hazard,
// stall and flush handling. Define FORWARDING_EN to bypass ex_result instead of stalling.
module alu_issue_stage
    import alu_pkg::*;
#(
    parameter int         DATA_W    = 32,
    parameter int         RA_W      = 5,
    parameter logic [5:0] FUNCT_SGT = 6'h2B
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              instr_valid,
    input  logic [31:0]       instr,
    output logic              instr_ready,
    output logic [RA_W-1:0]   rs_addr,
    output logic [RA_W-1:0]   rt_addr,
    input  logic [DATA_W-1:0] rs_data,
    input  logic [DATA_W-1:0] rt_data,
    input  logic [DATA_W-1:0] ex_result,
    input  logic              ex_stall,
    input  logic              branch_taken,
    output logic              alu_valid,
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    output logic [2:0]        alu_signal,
    output logic [4:0]        alu_shiftamt,
    output logic [RA_W-1:0]   alu_dest,
    output logic              alu_wen,
    output logic              illegal_instr
);

`ifdef FORWARDING_EN
    localparam logic FWD_EN = 1'b1;
`else
    localparam logic FWD_EN = 1'b0;
`endif

    logic [2:0]        dec_op_s;
    logic [1:0]        dec_bsel_s;
    logic              dec_sign_ext_s;
    logic [RA_W-1:0]   dec_dest_s;
    logic              dec_wen_s;
    logic              dec_uses_rs_s;
    logic              dec_uses_rt_s;
    logic              dec_illegal_s;
    logic              ex_live_s;
    logic              rs_match_s;
    logic              rt_match_s;
    logic              hazard_s;
    logic              hazard_stall_s;
    logic              accept_s;
    logic [DATA_W-1:0] rs_val_s;
    logic [DATA_W-1:0] rt_val_s;
    logic [DATA_W-1:0] imm_ext_s;
    logic [DATA_W-1:0] a_next_s;
    logic [DATA_W-1:0] b_next_s;
    logic [4:0]        shamt_next_s;

    assign rs_addr = instr[21 +: RA_W];
    assign rt_addr = instr[16 +: RA_W];

    alu_decode #(
        .RA_W      (RA_W),
        .FUNCT_SGT (FUNCT_SGT)
    ) u_decode (
        .opcode   (instr[31:26]),
        .funct    (instr[5:0]),
        .rt       (instr[16 +: RA_W]),
        .rd       (instr[11 +: RA_W]),
        .op       (dec_op_s),
        .bsel     (dec_bsel_s),
        .sign_ext (dec_sign_ext_s),
        .dest     (dec_dest_s),
        .wen      (dec_wen_s),
        .uses_rs  (dec_uses_rs_s),
        .uses_rt  (dec_uses_rt_s),
        .illegal  (dec_illegal_s)
    );

    // RAW detection against EX; only a live writer with a nonzero destination counts.
    always_comb begin
        ex_live_s      = alu_valid && alu_wen;
        rs_match_s     = ex_live_s && (rs_addr == alu_dest);
        rt_match_s     = ex_live_s && (rt_addr == alu_dest);
        hazard_s       = !ex_stall && ((dec_uses_rs_s && rs_match_s) || (dec_uses_rt_s && rt_match_s));
        hazard_stall_s = hazard_s && !FWD_EN;
        instr_ready    = branch_taken || (!ex_stall && !hazard_stall_s);
        accept_s       = instr_valid && instr_ready;
    end

    // Operand selection, including the bypass path from EX when forwarding is built in.
    always_comb begin
        rs_val_s = (FWD_EN && rs_match_s) ? ex_result : rs_data;
        rt_val_s = (FWD_EN && rt_match_s) ? ex_result : rt_data;
        if (dec_sign_ext_s) begin
            imm_ext_s = {{(DATA_W-IMM_W){instr[15]}}, instr[15:0]};
        end else begin
            imm_ext_s = {{(DATA_W-IMM_W){1'b0}}, instr[15:0]};
        end
        if (is_shift(dec_op_s)) begin
            a_next_s     = rt_val_s;
            shamt_next_s = instr[10:6];
        end else begin
            a_next_s     = rs_val_s;
            shamt_next_s = 5'd0;
        end
        case (dec_bsel_s)
            BSEL_RT:   b_next_s = rt_val_s;
            BSEL_IMM:  b_next_s = imm_ext_s;
            BSEL_ZERO: b_next_s = {DATA_W{1'b0}};
            default:   b_next_s = {DATA_W{1'b0}};
        endcase
    end

    // EX pipeline register: flush beats stall, stall beats issue; illegal words issue as bubbles.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            alu_valid     <= 1'b0;
            alu_a         <= {DATA_W{1'b0}};
            alu_b         <= {DATA_W{1'b0}};
            alu_signal    <= 3'd0;
            alu_shiftamt  <= 5'd0;
            alu_dest      <= {RA_W{1'b0}};
            alu_wen       <= 1'b0;
            illegal_instr <= 1'b0;
        end else if (branch_taken) begin
            alu_valid     <= 1'b0;
            alu_wen       <= 1'b0;
            illegal_instr <= 1'b0;
        end else if (ex_stall) begin
            illegal_instr <= 1'b0;
        end else if (!accept_s) begin
            alu_valid     <= 1'b0;
            alu_wen       <= 1'b0;
            illegal_instr <= 1'b0;
        end else if (dec_illegal_s) begin
            alu_valid     <= 1'b0;
            alu_wen       <= 1'b0;
            illegal_instr <= 1'b1;
        end else begin
            alu_valid     <= 1'b1;
            alu_a         <= a_next_s;
            alu_b         <= b_next_s;
            alu_signal    <= dec_op_s;
            alu_shiftamt  <= shamt_next_s;
            alu_dest      <= dec_dest_s;
            alu_wen       <= dec_wen_s;
            illegal_instr <= 1'b0;
        end
    end

endmodule
